// File: rtl/ssd_scan_driver_if.sv
// Register-bank load/write bus for the seven-segment scan driver.
// The master side drives bulk loads and single-digit writes; the driver is the slave.
interface ssd_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned AW         = 3
);
    logic                    ld_en;
    logic [4*NUM_DIGITS-1:0] ld_value;
    logic [NUM_DIGITS-1:0]   ld_dp;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [3:0]              wr_data;
    logic                    wr_dp;

    modport master (
        output ld_en, ld_value, ld_dp,
        output wr_en, wr_addr, wr_data, wr_dp
    );

    modport slave (
        input ld_en, ld_value, ld_dp,
        input wr_en, wr_addr, wr_data, wr_dp
    );
endinterface

// File: rtl/ssd_scan_driver.sv
// N-digit seven-segment multiplex driver: value/DP bank, timed scan with guard
// interval, blanking, blinking and leading-zero suppression; outputs active-low.
module ssd_scan_driver #(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned SCAN_DIV_BITS  = 18,
    parameter int unsigned BLINK_DIV_BITS = 25,
    parameter int unsigned AW             = 3
) (
    input  logic                  board_clk,
    input  logic                  Reset,
    ssd_scan_driver_if.slave      bus,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    input  logic                  lz_en,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [AW-1:0]         digit_idx,
    output logic                  frame_done
);
    localparam int unsigned GUARD_BITS = 4;

    logic [SCAN_DIV_BITS-1:0]  slot_cnt;
    logic [BLINK_DIV_BITS-1:0] blink_cnt;
    logic [3:0]                val_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]     dp_q;

    logic                  slot_end_c;
    logic                  guard_c;
    logic                  blink_off_c;
    logic                  visible_c;
    logic                  all_zero_c;
    logic [NUM_DIGITS-1:0] supp_c;
    logic [3:0]            cur_val_c;
    logic                  cur_dp_c;
    logic                  cur_blank_c;
    logic                  cur_blink_c;
    logic                  cur_supp_c;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0:    hex_to_seg = 7'b0000001;
            4'h1:    hex_to_seg = 7'b1001111;
            4'h2:    hex_to_seg = 7'b0010010;
            4'h3:    hex_to_seg = 7'b0000110;
            4'h4:    hex_to_seg = 7'b1001100;
            4'h5:    hex_to_seg = 7'b0100100;
            4'h6:    hex_to_seg = 7'b0100000;
            4'h7:    hex_to_seg = 7'b0001111;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0000100;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b1100000;
            4'hC:    hex_to_seg = 7'b0110001;
            4'hD:    hex_to_seg = 7'b1000010;
            4'hE:    hex_to_seg = 7'b0110000;
            default: hex_to_seg = 7'b0111000;
        endcase
    endfunction

    // Register bank: bulk load wins; out-of-range single writes match no digit.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) val_q[i] <= 4'd0;
            dp_q <= '0;
        end else if (bus.ld_en) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) val_q[i] <= bus.ld_value[4*i +: 4];
            dp_q <= bus.ld_dp;
        end else if (bus.wr_en) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (bus.wr_addr == AW'(i)) begin
                    val_q[i] <= bus.wr_data;
                    dp_q[i]  <= bus.wr_dp;
                end
            end
        end
    end

    // Selection of the scanned digit and its visibility.
    always_comb begin
        supp_c      = '0;
        all_zero_c  = 1'b1;
        cur_val_c   = 4'd0;
        cur_dp_c    = 1'b0;
        cur_blank_c = 1'b0;
        cur_blink_c = 1'b0;
        cur_supp_c  = 1'b0;

        // A digit is a leading zero when it and every digit above it are zero.
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            all_zero_c = all_zero_c && (val_q[k] == 4'd0);
            supp_c[k]  = lz_en && all_zero_c && (k != 0);
        end

        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (digit_idx == AW'(i)) begin
                cur_val_c   = val_q[i];
                cur_dp_c    = dp_q[i];
                cur_blank_c = blank_mask[i];
                cur_blink_c = blink_mask[i];
                cur_supp_c  = supp_c[i];
            end
        end

        slot_end_c  = &slot_cnt;
        guard_c     = (slot_cnt[SCAN_DIV_BITS-1 -: GUARD_BITS] == GUARD_BITS'(0));
        blink_off_c = blink_cnt[BLINK_DIV_BITS-1];
        visible_c   = !guard_c && !cur_blank_c && !(cur_blink_c && blink_off_c) && !cur_supp_c;
    end

    // Timebase, digit sequencing and registered display outputs.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            slot_cnt   <= '0;
            blink_cnt  <= '0;
            digit_idx  <= '0;
            frame_done <= 1'b0;
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            slot_cnt   <= slot_cnt + SCAN_DIV_BITS'(1);
            blink_cnt  <= blink_cnt + BLINK_DIV_BITS'(1);
            frame_done <= 1'b0;
            if (slot_end_c) begin
                if (digit_idx == AW'(NUM_DIGITS - 1)) begin
                    digit_idx  <= '0;
                    frame_done <= 1'b1;
                end else begin
                    digit_idx <= digit_idx + AW'(1);
                end
            end
            if (visible_c) begin
                an  <= ~(NUM_DIGITS'(1) << digit_idx);
                seg <= hex_to_seg(cur_val_c);
                dp  <= ~cur_dp_c;
            end else begin
                an  <= '1;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end
        end
    end
endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Parametrised N-digit seven-segment multiplex driver for the Nexys boards.
- Replaces the fixed single-digit scan, hex-to-SSD decoder and capture register currently built inline in the top level.
- Holds a per-digit value/DP register bank, loaded by bulk or single-digit writes.
- Scans the digits with a programmable rate, an anti-ghosting guard interval, per-digit blanking and blinking, and optional leading-zero suppression.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (1..8; need not be a power of two).
- SCAN_DIV_BITS, 18, each digit slot lasts 2^SCAN_DIV_BITS clocks (minimum 5).
- BLINK_DIV_BITS, 25, blink period is 2^BLINK_DIV_BITS clocks, 50% duty (must be > SCAN_DIV_BITS).
- AW, 3, digit address width; must satisfy 2^AW >= NUM_DIGITS.

Ports:
- board_clk  in  1  system clock (100 MHz).
- Reset  in  1  asynchronous, active-high.
- ld_en  in  1  bulk load strobe; one cycle.
- ld_value  in  4*NUM_DIGITS  nibble i goes to digit i.
- ld_dp  in  NUM_DIGITS  decimal point per digit (1 = lit).
- wr_en  in  1  single-digit write strobe.
- wr_addr  in  AW  digit index.
- wr_data  in  4  nibble.
- wr_dp  in  1  decimal point for the addressed digit.
- blank_mask  in  NUM_DIGITS  1 = digit always dark.
- blink_mask  in  NUM_DIGITS  1 = digit dark during blink-off phase.
- lz_en  in  1  leading-zero suppression enable.
- an  out  NUM_DIGITS  anodes, active-low.
- seg  out  7  {Ca..Cg}, active-low.
- dp  out  1  Dp cathode, active-low.
- digit_idx  out  AW  digit currently being scanned.
- frame_done  out  1  one-cycle pulse at completion of each full scan.

Behaviour:
- Reset (async): value and DP registers 0; slot counter, digit index and blink counter 0; an all 1; seg 7'h7F; dp 1; frame_done 0; digit_idx 0.

Register bank writes (effective on the clock edge):
- ld_en has priority over wr_en; simultaneous strobes perform only the bulk load.
- wr_en with wr_addr >= NUM_DIGITS is ignored.

Scan and timing:
- slot_cnt is SCAN_DIV_BITS wide and free-running.
- When slot_cnt = all-ones, digit_idx advances: NUM_DIGITS-1 wraps to 0.
- frame_done pulses high in the cycle after that wrap.
- Guard interval: while slot_cnt < 2^(SCAN_DIV_BITS-4), all anodes are off.
- blink_off = bit BLINK_DIV_BITS-1 of a free-running counter.

Per-digit visibility: the digit at digit_idx is visible when all of the following hold:
- outside the guard interval;
- blank_mask[idx] = 0;
- not (blink_mask[idx] and blink_off);
- not suppressed.

Leading-zero suppression:
- With lz_en = 1, digit k is suppressed if digit k and every digit above it hold 0 in their value registers.
- Digit 0 is never suppressed.
- The decimal point of a suppressed digit is also dark.

Outputs and latency:
- an, seg and dp are registered, reflecting the selection made in the previous cycle (1-cycle latency).
- A visible digit drives an[idx] = 0 with all others 1.
- When no digit is visible, an is all 1, seg = 7'h7F and dp = 1.
- A register write shows on the outputs no earlier than 1 cycle after the write edge, and only while that digit is being scanned.

Decode (abcdefg, active-low):
- 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
- 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
- 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
- C = 0110001, d = 1000010, E = 0110000, F = 0111000

Test Plan:
Bench parameters for all scenarios: NUM_DIGITS=3, SCAN_DIV_BITS=5, BLINK_DIV_BITS=8, AW=2. With these, each slot is 32 clocks and the guard is 2 clocks.
1. Bulk load and full scan:
   - Stimulus: ld_value=12'h3A1, ld_dp=3'b010, no masks.
   - Required: digit0 shows an=110, seg=1001111, dp=1; digit1 shows an=101, seg=0001000, dp=0; digit2 shows an=011, seg=0000110.
   - Required: an=111 for the first 2 output cycles of each 32-cycle slot; frame_done pulses once every 96 clocks.
2. Write priority and address range:
   - Same cycle: ld_en with ld_value=12'h000 plus wr_en with addr 1, data F. Required: all digits read back 0.
   - wr_en with addr 3. Required: ignored, no digit changes.
3. Leading-zero suppression:
   - Stimulus: value 12'h005, lz_en=1. Required: digits 2 and 1 dark (an=111 during their slots); digit 0 shows seg=0100100.
   - Stimulus: value 12'h000. Required: only digit 0 lit, seg=0000001.
4. Blink and blank:
   - Stimulus: blink_mask=3'b001. Required: digit0 dark during the 128 blink-off clocks and lit during the 128 blink-on clocks.
   - Stimulus: blank_mask=3'b100. Required: digit2 never lit.
5. Reset mid-scan:
   - Stimulus: assert Reset in the middle of digit1's slot.
   - Required: an=111, seg=7F, dp=1, digit_idx=0 immediately (asynchronously); register bank cleared.
   - Required after release: digit0's first slot starts with a full 2-cycle guard.
